// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round sequencer and the hash bank:
// controller state type, output bundle, sizing defaults and the H0..H7
// initial hash values.
package sha256_pkg;

  localparam int SHA_NUM_ROUNDS = 64;
  localparam int SHA_ROUND_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_WAIT_BLK = 3'd2,
    ST_LOAD     = 3'd3,
    ST_ROUNDS   = 3'd4,
    ST_ACCUM    = 3'd5,
    ST_FIN      = 3'd6
  } state_t;

  // Single-bit controller outputs, all derived from the state alone.
  typedef struct packed {
    logic blk_ready;
    logic set_hash;
    logic ld_work;
    logic sched_ld;
    logic round_en;
    logic ld_hash;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Initial hash value H[idx] (first 32 bits of the fractional parts of the
  // square roots of the first eight primes).
  function automatic logic [31:0] h_init(input logic [2:0] idx);
    logic [31:0] v;
    case (idx)
      3'd0:    v = 32'h6a09e667;
      3'd1:    v = 32'hbb67ae85;
      3'd2:    v = 32'h3c6ef372;
      3'd3:    v = 32'ha54ff53a;
      3'd4:    v = 32'h510e527f;
      3'd5:    v = 32'h9b05688c;
      3'd6:    v = 32'h1f83d9ab;
      3'd7:    v = 32'h5be0cd19;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  // Moore decode of the controller outputs for a given state.
  function automatic ctrl_out_t decode_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_IDLE:     o = '0;
      ST_INIT:     begin o.set_hash  = 1'b1; o.busy = 1'b1; end
      ST_WAIT_BLK: begin o.blk_ready = 1'b1; o.busy = 1'b1; end
      ST_LOAD:     begin o.sched_ld  = 1'b1; o.ld_work = 1'b1; o.busy = 1'b1; end
      ST_ROUNDS:   begin o.round_en  = 1'b1; o.busy = 1'b1; end
      ST_ACCUM:    begin o.ld_hash   = 1'b1; o.busy = 1'b1; end
      ST_FIN:      o.done = 1'b1;
      default:     o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Command / block-handshake / datapath-control bundle of the SHA-256 round
// sequencer. The master side issues commands and blocks; the slave side is
// the sequencer itself.
interface sha256_round_ctrl_if
  import sha256_pkg::*;
#(
  parameter int ROUND_W = SHA_ROUND_W
) ();

  logic               START;
  logic               ABORT;
  logic               BLK_VALID;
  logic               BLK_LAST;
  logic               BLK_READY;
  logic               SET_HASH;
  logic               LD_WORK;
  logic               SCHED_LD;
  logic               ROUND_EN;
  logic [ROUND_W-1:0] ROUND_IDX;
  logic               LD_HASH;
  logic               BUSY;
  logic               DONE;

  modport master (
    output START, ABORT, BLK_VALID, BLK_LAST,
    input  BLK_READY, SET_HASH, LD_WORK, SCHED_LD, ROUND_EN, ROUND_IDX,
           LD_HASH, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, BLK_VALID, BLK_LAST,
    output BLK_READY, SET_HASH, LD_WORK, SCHED_LD, ROUND_EN, ROUND_IDX,
           LD_HASH, BUSY, DONE
  );

endinterface

// File: rtl/sha256_round_cnt.sv
// Round counter: synchronous clear, saturating increment at NUM_ROUNDS-1 and
// a terminal-count flag that is decoded from the registered count.
module sha256_round_cnt #(
  parameter int NUM_ROUNDS = 64,
  parameter int ROUND_W    = 6
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               clr,
  input  logic               en,
  output logic [ROUND_W-1:0] cnt,
  output logic               tc
);

  localparam logic [ROUND_W-1:0] TC_VAL = ROUND_W'(NUM_ROUNDS - 1);

  logic [ROUND_W-1:0] cnt_r;

  // Count rounds; clear wins over enable and the count holds at the last round.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != TC_VAL)) begin
      cnt_r <= cnt_r + ROUND_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == TC_VAL);

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: initialises the hash bank, accepts 512-bit
// blocks from the block buffer and drives working-register load, 64 round
// enables and the hash accumulate for each block. Outputs are registered and
// follow the registered state only.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA_NUM_ROUNDS,
  parameter int ROUND_W    = SHA_ROUND_W
) (
  input logic                CLK,
  input logic                RESET_N,
  sha256_round_ctrl_if.slave bus
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               last_r;
  ctrl_out_t          out_r;
  logic               abort_s;
  logic               cnt_clr_s;
  logic               cnt_en_s;
  logic               cnt_tc_s;
  logic [ROUND_W-1:0] cnt_s;

  // Next state; an already-qualified abort overrides everything else.
  function automatic state_t next_state(
    input state_t s,
    input logic   abort,
    input logic   start,
    input logic   blk_valid,
    input logic   last,
    input logic   tc
  );
    state_t n;
    n = s;
    if (abort) begin
      n = ST_IDLE;
    end else begin
      case (s)
        ST_IDLE:     if (start)     n = ST_INIT;   else n = ST_IDLE;
        ST_INIT:     n = ST_WAIT_BLK;
        ST_WAIT_BLK: if (blk_valid) n = ST_LOAD;   else n = ST_WAIT_BLK;
        ST_LOAD:     n = ST_ROUNDS;
        ST_ROUNDS:   if (tc)        n = ST_ACCUM;  else n = ST_ROUNDS;
        ST_ACCUM:    if (last)      n = ST_FIN;    else n = ST_WAIT_BLK;
        ST_FIN:      if (start)     n = ST_INIT;   else n = ST_FIN;
        default:     n = ST_IDLE;
      endcase
    end
    return n;
  endfunction

  // Qualify abort (meaningless in IDLE) and derive the round counter controls.
  always_comb begin
    abort_s   = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    if (state_r != ST_IDLE) begin
      abort_s = bus.ABORT;
    end else begin
      abort_s = 1'b0;
    end
    cnt_clr_s = abort_s | (state_r == ST_LOAD);
    cnt_en_s  = (state_r == ST_ROUNDS);
  end

  // Select the next state from the registered state and the inputs.
  always_comb begin
    state_nxt_s = next_state(state_r, abort_s, bus.START, bus.BLK_VALID,
                             last_r, cnt_tc_s);
  end

  // State, last-block flag and output registers; outputs are decoded from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b0;
      out_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      out_r   <= decode_outputs(state_nxt_s);
      if (abort_s) begin
        last_r <= 1'b0;
      end else if ((state_r == ST_WAIT_BLK) && bus.BLK_VALID) begin
        last_r <= bus.BLK_LAST;
      end else begin
        last_r <= last_r;
      end
    end
  end

  sha256_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .cnt     (cnt_s),
    .tc      (cnt_tc_s)
  );

  assign bus.BLK_READY = out_r.blk_ready;
  assign bus.SET_HASH  = out_r.set_hash;
  assign bus.LD_WORK   = out_r.ld_work;
  assign bus.SCHED_LD  = out_r.sched_ld;
  assign bus.ROUND_EN  = out_r.round_en;
  assign bus.ROUND_IDX = cnt_s;
  assign bus.LD_HASH   = out_r.ld_hash;
  assign bus.BUSY      = out_r.busy;
  assign bus.DONE      = out_r.done;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl. A schedule-based reference model
// (message start cycle, handshake cycle, fixed per-block latencies) predicts
// every output each cycle; a small SHA-256 datapath model driven by the DUT's
// control outputs checks the "abc" digest end to end.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  sha256_round_ctrl_if #(.ROUND_W(SHA_ROUND_W)) bus ();

  sha256_round_ctrl #(
    .NUM_ROUNDS (SHA_NUM_ROUNDS),
    .ROUND_W    (SHA_ROUND_W)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference schedule model ----------------
  int n = 0;            // cycle number
  bit m_active;         // message in progress (BUSY expected)
  bit m_fin;            // digest complete (DONE expected)
  int m_start;          // cycle in which START was accepted
  int m_ready_from;     // first cycle BLK_READY is expected
  int m_hs;             // handshake cycle of the block in flight (-1 none)
  bit m_last;

  // ---------------- datapath model ----------------
  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] ABC_DIGEST [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  logic [31:0] H   [8];
  logic [31:0] wv  [8];
  logic [31:0] W   [16];
  logic [31:0] blk [16];
  int rnd_seen = 0;
  int sh_cnt   = 0;
  int lh_cnt   = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, n);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=progress (cycle %0d)", tag, n);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_fin = 1'b0; m_start = -10;
    m_ready_from = -1; m_hs = -1; m_last = 1'b0;
    rnd_seen = 0;
  endtask

  // Expected {BLK_READY,SET_HASH,LD_WORK,SCHED_LD,ROUND_EN,LD_HASH,BUSY,DONE}
  function automatic logic [7:0] exp_out();
    logic [7:0] e;
    e = 8'h00;
    e[7] = m_active && (m_ready_from >= 0) && (n >= m_ready_from) && (m_hs < 0);
    e[6] = m_active && (n == m_start + 1);
    e[5] = m_active && (m_hs >= 0) && (n == m_hs + 1);
    e[4] = e[5];
    e[3] = m_active && (m_hs >= 0) && (n >= m_hs + 2) && (n <= m_hs + 65);
    e[2] = m_active && (m_hs >= 0) && (n == m_hs + 66);
    e[1] = m_active;
    e[0] = m_fin;
    return e;
  endfunction

  // Advance the model by the inputs applied during cycle n.
  task automatic model_update();
    logic [7:0] e;
    e = exp_out();
    if ((m_active || m_fin) && bus.ABORT) begin
      m_active = 1'b0; m_fin = 1'b0; m_hs = -1; m_ready_from = -1;
    end else if (m_active) begin
      if (e[7] && bus.BLK_VALID) begin
        m_hs = n; m_last = bus.BLK_LAST;
      end else if ((m_hs >= 0) && (n == m_hs + 66)) begin
        if (m_last) begin
          m_active = 1'b0; m_fin = 1'b1;
        end else begin
          m_hs = -1; m_ready_from = n + 1;
        end
      end
    end else if (bus.START) begin
      m_active = 1'b1; m_fin = 1'b0; m_start = n;
      m_ready_from = n + 2; m_hs = -1;
    end
  endtask

  // Apply the DUT's control outputs of this cycle to the datapath model.
  task automatic dp_step();
    logic [31:0] t1, t2, nw;
    if (bus.SET_HASH) begin
      for (int i = 0; i < 8; i++) H[i] = h_init(3'(i));
      sh_cnt++;
    end
    if (bus.LD_WORK) begin
      for (int i = 0; i < 8; i++) wv[i] = H[i];
      rnd_seen = 0;
    end
    if (bus.SCHED_LD) begin
      for (int i = 0; i < 16; i++) W[i] = blk[i];
    end
    if (bus.ROUND_EN) begin
      t1 = wv[7] + bs1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[bus.ROUND_IDX] + W[0];
      t2 = bs0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      wv[7] = wv[6]; wv[6] = wv[5]; wv[5] = wv[4]; wv[4] = wv[3] + t1;
      wv[3] = wv[2]; wv[2] = wv[1]; wv[1] = wv[0]; wv[0] = t1 + t2;
      nw = ss1(W[14]) + W[9] + ss0(W[1]) + W[0];
      for (int i = 0; i < 15; i++) W[i] = W[i + 1];
      W[15] = nw;
      rnd_seen++;
    end
    if (bus.LD_HASH) begin
      chk("rounds_per_block", 64'(rnd_seen), 64'd64);
      for (int i = 0; i < 8; i++) H[i] = H[i] + wv[i];
      lh_cnt++;
    end
  endtask

  task automatic check_cycle();
    logic [7:0] e;
    e = exp_out();
    chk("outputs", 64'({bus.BLK_READY, bus.SET_HASH, bus.LD_WORK, bus.SCHED_LD,
                        bus.ROUND_EN, bus.LD_HASH, bus.BUSY, bus.DONE}), 64'(e));
    if (e[3]) chk("round_idx", 64'(bus.ROUND_IDX), 64'(n - m_hs - 2));
    if (!RESET_N) chk("reset_round_idx", 64'(bus.ROUND_IDX), 64'd0);
    chk("set_ld_hash_excl", 64'(bus.SET_HASH & bus.LD_HASH), 64'd0);
    chk("done_not_busy", 64'(bus.DONE & bus.BUSY), 64'd0);
  endtask

  task automatic cyc();
    @(negedge CLK);
    check_cycle();
    dp_step();
    model_update();
    @(posedge CLK);
    #1;
    n++;
  endtask

  task automatic clear_inputs();
    bus.START = 1'b0; bus.ABORT = 1'b0; bus.BLK_VALID = 1'b0; bus.BLK_LAST = 1'b0;
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h00000000;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic load_random_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  task automatic start_msg();
    bus.START = 1'b1; cyc(); bus.START = 1'b0;
  endtask

  task automatic send_block(input int delay, input bit last);
    int g;
    g = 0;
    while (!exp_out()[7] && g < 300) begin cyc(); g++; end
    if (g >= 300) tmo("wait_ready");
    repeat (delay) cyc();
    bus.BLK_VALID = 1'b1; bus.BLK_LAST = last;
    cyc();
    bus.BLK_VALID = 1'b0; bus.BLK_LAST = 1'($urandom);
  endtask

  task automatic run_to_end();
    int g;
    g = 0;
    while (m_active && g < 300) begin cyc(); g++; end
    if (g >= 300) tmo("wait_done");
  endtask

  task automatic run_to_round(input int idx);
    int g;
    g = 0;
    while (!(exp_out()[3] && (n - m_hs - 2 == idx)) && g < 300) begin cyc(); g++; end
    if (g >= 300) tmo("wait_round");
  endtask

  task automatic chk_digest(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_H%0d", tag, i), 64'(H[i]), 64'(ABC_DIGEST[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    clear_inputs();
    model_reset();
    for (int i = 0; i < 8; i++) begin H[i] = '0; wv[i] = '0; end
    for (int i = 0; i < 16; i++) W[i] = '0;
    @(posedge CLK); #1;
    repeat (3) cyc();
    RESET_N = 1'b1;
    repeat (2) cyc();

    // Single "abc" block presented as soon as the controller is ready.
    load_abc();
    sh_cnt = 0; lh_cnt = 0;
    bus.START = 1'b1; bus.BLK_VALID = 1'b1; bus.BLK_LAST = 1'b1;
    cyc();
    bus.START = 1'b0;
    run_to_end();
    bus.BLK_VALID = 1'b0;
    repeat (3) cyc();
    chk_digest("abc");
    chk("abc_set_hash_count", 64'(sh_cnt), 64'd1);
    chk("abc_ld_hash_count", 64'(lh_cnt), 64'd1);

    // Two blocks from FIN; the second arrives 5 cycles after BLK_READY.
    sh_cnt = 0; lh_cnt = 0;
    load_random_block();
    start_msg();
    send_block(0, 1'b0);
    load_random_block();
    send_block(5, 1'b1);
    run_to_end();
    repeat (2) cyc();
    chk("two_blk_ld_hash_count", 64'(lh_cnt), 64'd2);
    chk("two_blk_set_hash_count", 64'(sh_cnt), 64'd1);

    // Abort at round 30: no LD_HASH, no DONE.
    lh_cnt = 0;
    load_random_block();
    start_msg();
    send_block(1, 1'b1);
    run_to_round(30);
    bus.ABORT = 1'b1; cyc(); bus.ABORT = 1'b0;
    repeat (70) cyc();
    chk("abort_ld_hash_count", 64'(lh_cnt), 64'd0);

    // Clean message after abort, with START and BLK_VALID pulsed mid-rounds.
    load_abc();
    start_msg();
    send_block(2, 1'b1);
    repeat (10) cyc();
    bus.START = 1'b1; cyc(); bus.START = 1'b0;
    repeat (7) cyc();
    bus.BLK_VALID = 1'b1; bus.BLK_LAST = 1'b0; cyc(); bus.BLK_VALID = 1'b0;
    run_to_end();
    repeat (2) cyc();
    chk_digest("post_abort");

    // Asynchronous reset in the middle of the rounds.
    load_random_block();
    start_msg();
    send_block(0, 1'b1);
    run_to_round(20);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({bus.BLK_READY, bus.SET_HASH, bus.LD_WORK, bus.SCHED_LD,
                                  bus.ROUND_EN, bus.LD_HASH, bus.BUSY, bus.DONE}), 64'd0);
    chk("async_rst_round_idx", 64'(bus.ROUND_IDX), 64'd0);
    model_reset();
    repeat (2) cyc();
    RESET_N = 1'b1;
    cyc();
    load_abc();
    start_msg();
    send_block(3, 1'b1);
    run_to_end();
    repeat (2) cyc();
    chk_digest("post_reset");

    // Randomized inputs checked cycle by cycle against the schedule model.
    for (int i = 0; i < 2000; i++) begin
      bus.START     = ($urandom_range(0, 15) == 0);
      bus.ABORT     = ($urandom_range(0, 199) == 0);
      bus.BLK_VALID = ($urandom_range(0, 2) == 0);
      bus.BLK_LAST  = ($urandom_range(0, 2) == 0);
      cyc();
    end
    clear_inputs();
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
